// File: rtl/sc_game_statemachine.sv
// sc_game_statemachine
//   Game flow sequencer: IDLE -> READY countdown -> PLAY -> CRASH/GAMEOVER/WIN.
//   Drives one SELWIDTH-bit mux select per display row, and tracks lives and level.
//   Optional macro PAUSE_EN adds PAUSE(6): a press in PLAY freezes the game, and the
//   next press resumes it.
// Ports:
//   SC_GAMESTATEMACHINE_CLOCK_50         clock
//   SC_GAMESTATEMACHINE_RESET_InLow      synchronous active-low reset
//   SC_GAMESTATEMACHINE_START_InLow      start button (active low, already synchronised)
//   SC_GAMESTATEMACHINE_TICK_InHigh      one-cycle game tick
//   SC_GAMESTATEMACHINE_COLLISION_InHigh collision level, sampled on ticks
//   SC_GAMESTATEMACHINE_SIGNAL_OUT       row selects, row i at [i*SELWIDTH +: SELWIDTH]
//   SC_GAMESTATEMACHINE_STATE_OUT        state code
//   SC_GAMESTATEMACHINE_LIVES_OUT        lives remaining
//   SC_GAMESTATEMACHINE_LEVEL_OUT        current level
//   SC_GAMESTATEMACHINE_GAMEOVER_OutHigh high in GAMEOVER
module sc_game_statemachine #(
    parameter int ROWS        = 7,
    parameter int SELWIDTH    = 2,
    parameter int TICKWIDTH   = 8,
    parameter int READY_TICKS = 3,
    parameter int CRASH_TICKS = 4,
    parameter int LEVEL_TICKS = 20,
    parameter int LIVES       = 3,
    parameter int MAX_LEVEL   = 4
) (
    input  logic                     SC_GAMESTATEMACHINE_CLOCK_50,
    input  logic                     SC_GAMESTATEMACHINE_RESET_InLow,
    input  logic                     SC_GAMESTATEMACHINE_START_InLow,
    input  logic                     SC_GAMESTATEMACHINE_TICK_InHigh,
    input  logic                     SC_GAMESTATEMACHINE_COLLISION_InHigh,
    output logic [ROWS*SELWIDTH-1:0] SC_GAMESTATEMACHINE_SIGNAL_OUT,
    output logic [2:0]               SC_GAMESTATEMACHINE_STATE_OUT,
    output logic [2:0]               SC_GAMESTATEMACHINE_LIVES_OUT,
    output logic [3:0]               SC_GAMESTATEMACHINE_LEVEL_OUT,
    output logic                     SC_GAMESTATEMACHINE_GAMEOVER_OutHigh
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READY    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_CRASH    = 3'd3,
        ST_GAMEOVER = 3'd4,
        ST_WIN      = 3'd5,
        ST_PAUSE    = 3'd6
    } state_t;

    state_t                   r_state;
    logic [TICKWIDTH-1:0]     r_cnt;
    logic                     r_phase;
    logic                     r_start_q;
    logic [2:0]               r_lives;
    logic [3:0]               r_level;
    logic [ROWS*SELWIDTH-1:0] r_rows;
    logic                     r_gameover;

    logic                     w_press;
    logic                     w_pause_press;
    logic                     w_tick;
    logic [TICKWIDTH-1:0]     w_cnt_inc;
    logic [3:0]               w_level_inc;
    logic [2:0]               w_lives_dec;

    assign w_press     = r_start_q & ~SC_GAMESTATEMACHINE_START_InLow;
    assign w_tick      = SC_GAMESTATEMACHINE_TICK_InHigh;
    // Saturating arithmetic keeps every counter inside its legal range.
    assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_level_inc = (r_level >= 4'(MAX_LEVEL)) ? r_level : r_level + 4'd1;
    assign w_lives_dec = (r_lives == 3'd0) ? 3'd0 : r_lives - 3'd1;

`ifdef PAUSE_EN
    assign w_pause_press = w_press;
`else
    assign w_pause_press = 1'b0;   // PAUSE unreachable; presses in PLAY ignored
`endif

    // Row select image for a given state and phase. The image is computed for
    // the state being entered, so the row outputs stay registered.
    function automatic logic [ROWS*SELWIDTH-1:0] f_rows(input state_t st, input logic ph);
        logic [SELWIDTH-1:0] code;
        f_rows = '0;
        for (int i = 0; i < ROWS; i++) begin
            case (st)
                ST_READY, ST_GAMEOVER: code = SELWIDTH'(1);
                ST_PLAY, ST_PAUSE:     code = SELWIDTH'(2);
                // Checkerboard: row i lit when (i + phase) is even.
                ST_CRASH:              code = ((i[0] ^ ph) == 1'b0) ? SELWIDTH'(3) : '0;
                ST_WIN:                code = ph ? SELWIDTH'(2) : SELWIDTH'(1);
                default:               code = '0;
            endcase
            f_rows[i*SELWIDTH +: SELWIDTH] = code;
        end
    endfunction

    always_ff @(posedge SC_GAMESTATEMACHINE_CLOCK_50) begin
        if (!SC_GAMESTATEMACHINE_RESET_InLow) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_phase    <= 1'b0;
            r_start_q  <= 1'b1;
            r_lives    <= 3'(LIVES);
            r_level    <= 4'd1;
            r_rows     <= '0;
            r_gameover <= 1'b0;
        end else begin
            r_start_q <= SC_GAMESTATEMACHINE_START_InLow;
            case (r_state)
                ST_IDLE: begin
                    // A press takes priority; any tick in the same cycle is dropped.
                    if (w_press) begin
                        r_lives <= 3'(LIVES);
                        r_level <= 4'd1;
                        r_cnt   <= '0;
                        r_state <= ST_READY;
                        r_rows  <= f_rows(ST_READY, 1'b0);
                    end
                end
                ST_READY: begin
                    if (w_tick) begin
                        if (w_cnt_inc == TICKWIDTH'(READY_TICKS)) begin
                            r_cnt   <= '0;
                            r_state <= ST_PLAY;
                            r_rows  <= f_rows(ST_PLAY, 1'b0);
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                ST_PLAY: begin
                    if (w_pause_press) begin
                        r_state <= ST_PAUSE;
                        r_rows  <= f_rows(ST_PAUSE, 1'b0);
                    end else if (w_tick) begin
                        // A collision beats a level boundary on the same tick.
                        if (SC_GAMESTATEMACHINE_COLLISION_InHigh) begin
                            r_lives <= w_lives_dec;
                            r_cnt   <= '0;
                            r_phase <= 1'b0;
                            r_state <= ST_CRASH;
                            r_rows  <= f_rows(ST_CRASH, 1'b0);
                        end else if (w_cnt_inc == TICKWIDTH'(LEVEL_TICKS)) begin
                            r_cnt   <= '0;
                            r_level <= w_level_inc;
                            if (w_level_inc == 4'(MAX_LEVEL)) begin
                                r_phase <= 1'b0;
                                r_state <= ST_WIN;
                                r_rows  <= f_rows(ST_WIN, 1'b0);
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                ST_CRASH: begin
                    if (w_tick) begin
                        if (w_cnt_inc == TICKWIDTH'(CRASH_TICKS)) begin
                            r_cnt <= '0;
                            if (r_lives == 3'd0) begin
                                r_state    <= ST_GAMEOVER;
                                r_gameover <= 1'b1;
                                r_rows     <= f_rows(ST_GAMEOVER, 1'b0);
                            end else begin
                                r_state <= ST_PLAY;
                                r_rows  <= f_rows(ST_PLAY, 1'b0);
                            end
                        end else begin
                            r_cnt   <= w_cnt_inc;
                            r_phase <= ~r_phase;
                            r_rows  <= f_rows(ST_CRASH, ~r_phase);
                        end
                    end
                end
                ST_GAMEOVER, ST_WIN: begin
                    if (w_press) begin
                        r_state    <= ST_IDLE;
                        r_gameover <= 1'b0;
                        r_rows     <= '0;
                    end else if (w_tick && r_state == ST_WIN) begin
                        r_phase <= ~r_phase;
                        r_rows  <= f_rows(ST_WIN, ~r_phase);
                    end
                end
                ST_PAUSE: begin
                    // Counter, lives and level are frozen; only a press resumes.
                    if (w_press) begin
                        r_state <= ST_PLAY;
                        r_rows  <= f_rows(ST_PLAY, 1'b0);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rows  <= '0;
                end
            endcase
        end
    end

    assign SC_GAMESTATEMACHINE_SIGNAL_OUT       = r_rows;
    assign SC_GAMESTATEMACHINE_STATE_OUT        = r_state;
    assign SC_GAMESTATEMACHINE_LIVES_OUT        = r_lives;
    assign SC_GAMESTATEMACHINE_LEVEL_OUT        = r_level;
    assign SC_GAMESTATEMACHINE_GAMEOVER_OutHigh = r_gameover;

endmodule

// File: tb/tb_sc_game_statemachine.sv
// Directed bench for sc_game_statemachine with default parameters (7 rows x 2 bits).
module tb_sc_game_statemachine;

    localparam logic [13:0] ROWS_0    = 14'h0000;
    localparam logic [13:0] ROWS_1    = 14'h1555;  // 01 x7
    localparam logic [13:0] ROWS_2    = 14'h2AAA;  // 10 x7
    localparam logic [13:0] ROWS_CR0  = 14'h3333;  // 3,0,3,0,3,0,3 (row0 at LSB)
    localparam logic [13:0] ROWS_CR1  = 14'h0CCC;  // 0,3,0,3,0,3,0

    logic        clk;
    logic        rst_n;
    logic        start_n;
    logic        tick;
    logic        col;
    logic [13:0] sig;
    logic [2:0]  state;
    logic [2:0]  lives;
    logic [3:0]  level;
    logic        gover;

    int n_chk;
    int n_fail;

    sc_game_statemachine dut (
        .SC_GAMESTATEMACHINE_CLOCK_50        (clk),
        .SC_GAMESTATEMACHINE_RESET_InLow     (rst_n),
        .SC_GAMESTATEMACHINE_START_InLow     (start_n),
        .SC_GAMESTATEMACHINE_TICK_InHigh     (tick),
        .SC_GAMESTATEMACHINE_COLLISION_InHigh(col),
        .SC_GAMESTATEMACHINE_SIGNAL_OUT      (sig),
        .SC_GAMESTATEMACHINE_STATE_OUT       (state),
        .SC_GAMESTATEMACHINE_LIVES_OUT       (lives),
        .SC_GAMESTATEMACHINE_LEVEL_OUT       (level),
        .SC_GAMESTATEMACHINE_GAMEOVER_OutHigh(gover)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic tk(input logic c);
        tick = 1'b1;
        col  = c;
        @(negedge clk);
        tick = 1'b0;
        col  = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tk(1'b0);
    endtask

    task automatic press();
        start_n = 1'b0;
        @(negedge clk);
        start_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start_n = 1'b1;
        tick    = 1'b0;
        col     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rows", 32'(sig), 32'(ROWS_0));
        chk("rst_state", 32'(state), 0);
        chk("rst_lives", 32'(lives), 3);
        chk("rst_level", 32'(level), 1);
        chk("rst_gover", 32'(gover), 0);
        rst_n = 1'b1;

        // Held button: one press, READY entered.
        start_n = 1'b0;
        repeat (10) @(negedge clk);
        chk("hold_state", 32'(state), 1);
        chk("ready_rows", 32'(sig), 32'(ROWS_1));
        start_n = 1'b1;
        @(negedge clk);
        ticks(2);
        chk("ready_2t", 32'(state), 1);
        tk(1'b0);
        chk("play_state", 32'(state), 2);
        chk("play_rows", 32'(sig), 32'(ROWS_2));

        // Level advance after 20 clean ticks.
        ticks(19);
        chk("lvl_19", 32'(level), 1);
        tk(1'b0);
        chk("lvl_20", 32'(level), 2);
        chk("lvl_state", 32'(state), 2);

        // Collision on the level boundary tick: crash wins, level held.
        ticks(19);
        tk(1'b1);
        chk("crash_state", 32'(state), 3);
        chk("crash_lives", 32'(lives), 2);
        chk("crash_level", 32'(level), 2);
        chk("crash_rows0", 32'(sig), 32'(ROWS_CR0));
        tk(1'b0);
        chk("crash_rows1", 32'(sig), 32'(ROWS_CR1));
        ticks(2);
        chk("crash_3t", 32'(state), 3);
        chk("crash_rows3", 32'(sig), 32'(ROWS_CR1));
        tk(1'b0);
        chk("crash_back", 32'(state), 2);
        chk("crash_back_rows", 32'(sig), 32'(ROWS_2));

        // Two more crashes exhaust the lives.
        tk(1'b1);
        ticks(4);
        chk("crash2_lives", 32'(lives), 1);
        chk("crash2_state", 32'(state), 2);
        tk(1'b1);
        chk("crash3_lives", 32'(lives), 0);
        ticks(4);
        chk("go_state", 32'(state), 4);
        chk("go_flag", 32'(gover), 1);
        chk("go_rows", 32'(sig), 32'(ROWS_1));
        press();
        chk("go_idle", 32'(state), 0);
        chk("go_idle_rows", 32'(sig), 32'(ROWS_0));
        chk("go_idle_flag", 32'(gover), 0);

        // Tick and press together in IDLE: press taken, tick not counted.
        start_n = 1'b0;
        tick    = 1'b1;
        @(negedge clk);
        start_n = 1'b1;
        tick    = 1'b0;
        chk("new_state", 32'(state), 1);
        chk("new_lives", 32'(lives), 3);
        chk("new_level", 32'(level), 1);
        ticks(2);
        chk("new_ready2", 32'(state), 1);
        tk(1'b0);
        chk("new_play", 32'(state), 2);

        // Run to MAX_LEVEL and WIN.
        ticks(59);
        chk("pre_win_level", 32'(level), 3);
        chk("pre_win_state", 32'(state), 2);
        tk(1'b0);
        chk("win_state", 32'(state), 5);
        chk("win_level", 32'(level), 4);
        chk("win_rows0", 32'(sig), 32'(ROWS_1));
        tk(1'b0);
        chk("win_rows1", 32'(sig), 32'(ROWS_2));
        tk(1'b0);
        chk("win_rows2", 32'(sig), 32'(ROWS_1));
        press();
        chk("win_idle", 32'(state), 0);

        // Collision on the 20th tick at level 1, then reset mid-CRASH.
        press();
        ticks(3);
        ticks(19);
        tk(1'b1);
        chk("c20_state", 32'(state), 3);
        chk("c20_level", 32'(level), 1);
        chk("c20_lives", 32'(lives), 2);
        tk(1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_state", 32'(state), 0);
        chk("midrst_rows", 32'(sig), 32'(ROWS_0));
        chk("midrst_lives", 32'(lives), 3);

        // Press in PLAY: pause with the macro, ignored without it.
        press();
        ticks(3);
        ticks(5);
        press();
`ifdef PAUSE_EN
        chk("pause_state", 32'(state), 6);
        chk("pause_rows", 32'(sig), 32'(ROWS_2));
        tk(1'b1);
        ticks(29);
        chk("pause_hold_state", 32'(state), 6);
        chk("pause_hold_level", 32'(level), 1);
        chk("pause_hold_lives", 32'(lives), 3);
        press();
`endif
        chk("play_after_press", 32'(state), 2);
        ticks(14);
        chk("resume_lvl", 32'(level), 1);
        tk(1'b0);
        chk("resume_lvl_up", 32'(level), 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
